sram_req_arbiter: RTL and testbench

- Shares one SRAM-like memory port (req/addr_ok/data_ok handshake) between the instruction-fetch requester and the MEM-stage data requester.
- Grants one request per cycle and records each accepted request's owner in an in-order ID queue.
- Routes each returning data_ok/rdata to the owner at the queue head.
- Sits between the IF/MEM stages and the memory-side bridge.

---
 rtl/sram_req_arbiter_pkg.sv | 21 ++
 rtl/arb_id_fifo.sv | 66 ++++++
 rtl/sram_req_arbiter.sv | 172 +++++++++++++++++
 tb/tb_sram_req_arbiter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/sram_req_arbiter_pkg.sv
// Shared definitions for the SRAM request arbiter: requester IDs, arbiter
// state encodings and SRAM transfer size encodings.
package sram_req_arbiter_pkg;

    // Owner IDs stored in the in-order response queue.
    localparam logic ID_INST = 1'b0;
    localparam logic ID_DATA = 1'b1;

    // Arbiter lock states.
    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKED_I = 2'd1,
        LOCKED_D = 2'd2
    } arb_state_t;

    // SRAM-like transfer size encodings.
    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/arb_id_fifo.sv
// In-order owner-ID queue for accepted-but-not-returned memory transactions.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   push, push_id enqueue one owner ID (ignored when full)
//   pop           dequeue the head entry (ignored when empty)
//   full, empty   occupancy flags
//   head          owner ID at the queue head
module arb_id_fifo #(
    parameter int unsigned DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic push_id,
    input  logic pop,
    output logic full,
    output logic empty,
    output logic head
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] ids_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign head    = ids_q[rd_ptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Pointer increment with explicit wrap so non-power-of-two depths stay safe.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            ids_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                ids_q[wr_ptr_q] <= push_id;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/sram_req_arbiter.sv
// Shares one SRAM-like memory port between the instruction-fetch requester
// and the MEM-stage data requester. One request is granted per cycle; each
// accepted request's owner is queued so in-order responses can be routed back.
//
// Optional feature: define ARB_ROUND_ROBIN_EN to replace fixed data priority
// with last-winner round-robin arbitration in the UNLOCKED state.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   inst_*  (req/wr/size/wstrb/addr/wdata in; addr_ok/data_ok/rdata out)
//   data_*  (same as inst_*, MEM-stage side)
//   mem_req, mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata  to memory
//   mem_addr_ok, mem_data_ok, mem_rdata                       from memory
module sram_req_arbiter
    import sram_req_arbiter_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 2,
    parameter int unsigned ADDR_W          = 32,
    parameter int unsigned DATA_W          = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              inst_req,
    input  logic              inst_wr,
    input  logic [1:0]        inst_size,
    input  logic [3:0]        inst_wstrb,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic [DATA_W-1:0] inst_wdata,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,

    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [3:0]        data_wstrb,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,

    output logic              mem_req,
    output logic              mem_wr,
    output logic [1:0]        mem_size,
    output logic [3:0]        mem_wstrb,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_addr_ok,
    input  logic              mem_data_ok,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t state_q;
    arb_state_t state_d;
    logic       block_q;
    logic       block;
    logic       grant_id;
    logic       granted_req;
    logic       accept;
    logic       sel_inst;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_head;
    logic       pop;

    // Handshakes stay quiet during reset and for one cycle after it.
    always_ff @(posedge clk) begin
        block_q <= rst;
    end
    assign block = rst | block_q;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_q;

    // Last accepted owner; starts at data so inst wins the first conflict.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= ID_DATA;
        end else if (accept) begin
            last_q <= grant_id;
        end
    end
`endif

    // Arbiter state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= UNLOCKED;
        end else begin
            state_q <= state_d;
        end
    end

    // Grant selection, credit gating and next-state logic.
    always_comb begin
        grant_id    = ID_DATA;
        granted_req = 1'b0;
        mem_req     = 1'b0;
        accept      = 1'b0;
        state_d     = state_q;

        case (state_q)
            LOCKED_I: grant_id = ID_INST;
            LOCKED_D: grant_id = ID_DATA;
            default: begin
`ifdef ARB_ROUND_ROBIN_EN
                if (data_req && inst_req) begin
                    grant_id = (last_q == ID_DATA) ? ID_INST : ID_DATA;
                end else begin
                    grant_id = (data_req || !inst_req) ? ID_DATA : ID_INST;
                end
`else
                grant_id = (data_req || !inst_req) ? ID_DATA : ID_INST;
`endif
            end
        endcase

        granted_req = (grant_id == ID_DATA) ? data_req : inst_req;
        // Full is sampled from registered occupancy only; a same-cycle pop
        // never reopens the port, keeping mem_data_ok off the mem_req path.
        mem_req     = granted_req & ~fifo_full & ~block;
        accept      = mem_req & mem_addr_ok;

        case (state_q)
            UNLOCKED: begin
                if (mem_req && !mem_addr_ok) begin
                    state_d = (grant_id == ID_DATA) ? LOCKED_D : LOCKED_I;
                end
            end
            LOCKED_I, LOCKED_D: begin
                if (accept) begin
                    state_d = UNLOCKED;
                end
            end
            default: state_d = UNLOCKED;
        endcase
    end

    // Request field mux; idles on the data side whenever nothing is presented.
    assign sel_inst  = mem_req & (grant_id == ID_INST);
    assign mem_wr    = sel_inst ? inst_wr    : data_wr;
    assign mem_size  = sel_inst ? inst_size  : data_size;
    assign mem_wstrb = sel_inst ? inst_wstrb : data_wstrb;
    assign mem_addr  = sel_inst ? inst_addr  : data_addr;
    assign mem_wdata = sel_inst ? inst_wdata : data_wdata;

    assign inst_addr_ok = accept & (grant_id == ID_INST);
    assign data_addr_ok = accept & (grant_id == ID_DATA);

    // Responses with an empty queue are protocol errors and are dropped.
    assign pop          = mem_data_ok & ~fifo_empty & ~block;
    assign inst_data_ok = pop & (fifo_head == ID_INST);
    assign data_data_ok = pop & (fifo_head == ID_DATA);
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (accept),
        .push_id (grant_id),
        .pop     (pop),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .head    (fifo_head)
    );

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Self-checking bench for sram_req_arbiter: cycle-driven stimulus, owner IDs
// predicted from the arbitration rules, responses checked through a scoreboard.
module tb_sram_req_arbiter;
    import sram_req_arbiter_pkg::*;

    localparam logic [31:0] DATA_ADDR  = 32'h8000_0010;
    localparam logic [31:0] DATA_WDATA = 32'hDEAD_BEEF;

    typedef struct packed {
        logic        id;
        logic [31:0] rdata;
    } resp_t;

    logic        clk;
    logic        rst;
    logic        inst_req, inst_wr;
    logic [1:0]  inst_size;
    logic [3:0]  inst_wstrb;
    logic [31:0] inst_addr, inst_wdata;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;

    int    n_checks = 0;
    int    n_errors = 0;
    logic  own_q[$];
    resp_t sb_q[$];

    sram_req_arbiter #(
        .MAX_OUTSTANDING (2),
        .ADDR_W          (32),
        .DATA_W          (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .inst_req     (inst_req),
        .inst_wr      (inst_wr),
        .inst_size    (inst_size),
        .inst_wstrb   (inst_wstrb),
        .inst_addr    (inst_addr),
        .inst_wdata   (inst_wdata),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_wstrb   (data_wstrb),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .mem_req      (mem_req),
        .mem_wr       (mem_wr),
        .mem_size     (mem_size),
        .mem_wstrb    (mem_wstrb),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_addr_ok  (mem_addr_ok),
        .mem_data_ok  (mem_data_ok),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, check combinational outputs, advance.
    // sel: 0 = mem fields from inst side, 1 = from data side, other = unchecked.
    task automatic run_cycle(input string tag, input logic rst_v,
                             input logic ireq, input logic dreq,
                             input logic aok, input logic dok, input logic [31:0] rd,
                             input logic exp_mreq, input logic exp_iaok,
                             input logic exp_daok, input int sel);
        logic  have;
        resp_t e;
        have        = 1'b0;
        rst         = rst_v;
        inst_req    = ireq;
        data_req    = dreq;
        mem_addr_ok = aok;
        mem_data_ok = dok;
        mem_rdata   = rd;
        if (dok && !rst_v && own_q.size() > 0) begin
            sb_q.push_back('{id: own_q.pop_front(), rdata: rd});
            have = 1'b1;
        end
        #1;
        check({tag, "/mem_req"},      72'(mem_req),      72'(exp_mreq));
        check({tag, "/inst_addr_ok"}, 72'(inst_addr_ok), 72'(exp_iaok));
        check({tag, "/data_addr_ok"}, 72'(data_addr_ok), 72'(exp_daok));
        if (sel == 0) begin
            check({tag, "/fields"}, 72'({mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata}),
                  72'({1'b0, SIZE_WORD, 4'hF, inst_addr, 32'h0}));
        end else if (sel == 1) begin
            check({tag, "/fields"}, 72'({mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata}),
                  72'({1'b1, SIZE_HALF, 4'h3, DATA_ADDR, DATA_WDATA}));
        end
        if (have) begin
            e = sb_q.pop_front();
            check({tag, "/inst_data_ok"}, 72'(inst_data_ok), 72'(e.id == ID_INST));
            check({tag, "/data_data_ok"}, 72'(data_data_ok), 72'(e.id == ID_DATA));
            check({tag, "/rdata"}, 72'((e.id == ID_INST) ? inst_rdata : data_rdata), 72'(e.rdata));
        end else begin
            check({tag, "/no_data_ok"}, 72'({inst_data_ok, data_data_ok}), 72'(2'b00));
        end
        if (exp_iaok) own_q.push_back(ID_INST);
        if (exp_daok) own_q.push_back(ID_DATA);
        if (rst_v) begin
            own_q.delete();
            sb_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic first_inst;
`ifdef ARB_ROUND_ROBIN_EN
        first_inst = 1'b1;
`else
        first_inst = 1'b0;
`endif
        rst = 1'b1;
        inst_req = 0; inst_wr = 0; inst_size = SIZE_WORD; inst_wstrb = 4'hF;
        inst_addr = 32'h1C00_0000; inst_wdata = 32'h0;
        data_req = 0; data_wr = 1; data_size = SIZE_HALF; data_wstrb = 4'h3;
        data_addr = DATA_ADDR; data_wdata = DATA_WDATA;
        mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 32'h0;
        @(posedge clk);
        #1;

        // Reset: handshakes held low in the reset cycle and the one after.
        run_cycle("rst0",  1, 1, 1, 1, 1, 32'h1111, 0, 0, 0, -1);
        run_cycle("rst1",  0, 1, 1, 1, 1, 32'h2222, 0, 0, 0, -1);
        run_cycle("idle",  0, 0, 0, 0, 0, 32'h0,    0, 0, 0, 1);

        // Single instruction fetch, response three cycles later.
        run_cycle("if_c0", 0, 1, 0, 1, 0, 32'h0, 1, 1, 0, 0);
        run_cycle("if_c1", 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, -1);
        run_cycle("if_c2", 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, -1);
        run_cycle("if_c3", 0, 0, 0, 0, 1, 32'h0280_0413, 0, 0, 0, -1);

        // Conflict from a fresh reset: priority depends on build.
        inst_addr = 32'h1C00_0040;
        run_cycle("cf_rst", 1, 0, 0, 0, 0, 32'h0, 0, 0, 0, -1);
        run_cycle("cf_rs1", 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, -1);
        if (first_inst) begin
            run_cycle("cf_c0", 0, 1, 1, 1, 0, 32'h0, 1, 1, 0, 0);
            run_cycle("cf_c1", 0, 0, 1, 1, 0, 32'h0, 1, 0, 1, 1);
        end else begin
            run_cycle("cf_c0", 0, 1, 1, 1, 0, 32'h0, 1, 0, 1, 1);
            run_cycle("cf_c1", 0, 1, 0, 1, 0, 32'h0, 1, 1, 0, 0);
        end
        run_cycle("cf_r0", 0, 0, 0, 0, 1, 32'hA0A0_0001, 0, 0, 0, -1);
        run_cycle("cf_r1", 0, 0, 0, 0, 1, 32'hA0A0_0002, 0, 0, 0, -1);

        // Lock: inst stalled on addr_ok keeps the grant over a later data_req.
        run_cycle("lk_c0", 0, 1, 0, 0, 0, 32'h0, 1, 0, 0, 0);
        run_cycle("lk_c1", 0, 1, 1, 0, 0, 32'h0, 1, 0, 0, 0);
        run_cycle("lk_c2", 0, 1, 1, 0, 0, 32'h0, 1, 0, 0, 0);
        run_cycle("lk_c3", 0, 1, 1, 0, 0, 32'h0, 1, 0, 0, 0);
        run_cycle("lk_c4", 0, 1, 1, 1, 0, 32'h0, 1, 1, 0, 0);
        run_cycle("lk_c5", 0, 0, 1, 1, 0, 32'h0, 1, 0, 1, 1);
        run_cycle("lk_r0", 0, 0, 0, 0, 1, 32'hB0B0_0001, 0, 0, 0, -1);
        run_cycle("lk_r1", 0, 0, 0, 0, 1, 32'hB0B0_0002, 0, 0, 0, -1);

        // Credit limit, same-cycle push/pop and pointer wrap.
        run_cycle("fu_c0", 0, 0, 1, 1, 0, 32'h0, 1, 0, 1, 1);
        run_cycle("fu_c1", 0, 1, 0, 1, 0, 32'h0, 1, 1, 0, 0);
        run_cycle("fu_c2", 0, 0, 1, 1, 0, 32'h0, 0, 0, 0, 1);
        run_cycle("fu_c3", 0, 0, 1, 1, 1, 32'hC0C0_0001, 0, 0, 0, 1);
        run_cycle("fu_c4", 0, 0, 1, 1, 1, 32'hC0C0_0002, 1, 0, 1, 1);
        run_cycle("fu_c5", 0, 1, 0, 1, 1, 32'hC0C0_0003, 1, 1, 0, 0);
        run_cycle("fu_c6", 0, 0, 0, 0, 1, 32'hC0C0_0004, 0, 0, 0, -1);
        run_cycle("stray", 0, 0, 0, 0, 1, 32'hC0C0_0005, 0, 0, 0, -1);

        // Reset with two outstanding: queue emptied, stray response ignored.
        run_cycle("ro_c0", 0, 0, 1, 1, 0, 32'h0, 1, 0, 1, 1);
        run_cycle("ro_c1", 0, 1, 0, 1, 0, 32'h0, 1, 1, 0, 0);
        run_cycle("ro_rs", 1, 1, 0, 1, 1, 32'hD0D0_0001, 0, 0, 0, -1);
        run_cycle("ro_c2", 0, 1, 0, 1, 1, 32'hD0D0_0002, 0, 0, 0, -1);
        run_cycle("ro_c3", 0, 1, 0, 1, 0, 32'h0, 1, 1, 0, 0);
        run_cycle("ro_c4", 0, 0, 0, 0, 1, 32'hD0D0_0003, 0, 0, 0, -1);

        check("sb_drained", 72'(sb_q.size() + own_q.size()), 72'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
